// File: rtl/matrix_scan_driver.sv
// rtl/matrix_scan_driver.sv - N x N multi-colour LED matrix scan driver for 74HC595-style chains
// Double-buffered frame store, tick-paced row/colour slot scan, tear-free swap at frame end.
module matrix_scan_driver #(
  parameter int N       = 8,
  parameter int COLORS  = 2,
  parameter int CLK_DIV = 1350,
  localparam int CW = (COLORS > 1) ? $clog2(COLORS) : 1,
  localparam int RW = $clog2(N),
  localparam int DW = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr_en,
  input  logic [CW-1:0]     wr_color,
  input  logic [RW-1:0]     wr_row,
  input  logic [N-1:0]      wr_data,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              frame_done,
  output logic              ser_data,
  output logic [COLORS-1:0] col_sel,
  output logic              ser_clk,
  output logic              ser_latch,
  output logic              oe_n
);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     div_q;
  logic              tick;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     color_q, color_d;
  logic [RW-1:0]     bit_q, bit_d;
  logic              phase_q, phase_d;
  logic              front_q, front_d;
  logic              pend_q, pend_d;
  logic              ser_data_q, ser_data_d;
  logic [COLORS-1:0] col_sel_q, col_sel_d;
  logic              ser_clk_q, ser_clk_d;
  logic              latch_q, latch_d;
  logic              oe_n_q, oe_n_d;
  logic              ack_q, ack_d;
  logic              done_q, done_d;
  logic              ld, idle_out, frame_end;

  logic [N-1:0] mem_q [2][COLORS][N];

  assign tick = (div_q == DW'(CLK_DIV));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= tick ? '0 : div_q + 1'b1;
    end
  end

  // Host always writes the plane that is not on display.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[~front_q][wr_color][wr_row] <= wr_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    color_d    = color_q;
    bit_d      = bit_q;
    phase_d    = phase_q;
    front_d    = front_q;
    pend_d     = pend_q | swap_req;
    ser_data_d = ser_data_q;
    col_sel_d  = col_sel_q;
    ser_clk_d  = ser_clk_q;
    latch_d    = latch_q;
    oe_n_d     = oe_n_q;
    ack_d      = 1'b0;
    done_d     = 1'b0;
    ld         = 1'b0;
    idle_out   = 1'b0;
    frame_end  = 1'b0;

    if (tick) begin
      unique case (state_q)
        IDLE: begin
          idle_out = 1'b1;
          if (enable) begin
            state_d = SHIFT;
            row_d   = '0;
            color_d = '0;
            bit_d   = RW'(N - 1);
            phase_d = 1'b0;
            ld      = 1'b1;
          end
        end
        SHIFT: begin
          if (!phase_q) begin
            phase_d   = 1'b1;
            ser_clk_d = 1'b1;
          end else if (bit_q == '0) begin
            state_d   = LATCH;
            ser_clk_d = 1'b0;
            latch_d   = 1'b1;
            oe_n_d    = 1'b0;
          end else begin
            bit_d   = bit_q - 1'b1;
            phase_d = 1'b0;
            ld      = 1'b1;
          end
        end
        LATCH: begin
          latch_d = 1'b0;
          // Colour advances fastest; row steps when the last colour plane is done.
          if (color_q == CW'(COLORS - 1)) begin
            color_d = '0;
            if (row_q == RW'(N - 1)) begin
              row_d     = '0;
              frame_end = 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            color_d = color_q + 1'b1;
          end
          if (enable) begin
            state_d = SHIFT;
            bit_d   = RW'(N - 1);
            phase_d = 1'b0;
            ld      = 1'b1;
          end else begin
            state_d  = IDLE;
            idle_out = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (frame_end) begin
      done_d = 1'b1;
      if (pend_q) begin
        front_d = ~front_q;
        ack_d   = 1'b1;
        pend_d  = swap_req;
      end
    end

    if (idle_out) begin
      ser_data_d = 1'b0;
      col_sel_d  = '1;
      ser_clk_d  = 1'b0;
      latch_d    = 1'b0;
      oe_n_d     = 1'b1;
    end

    // Present the next bit from the plane that is on display after any swap this clk.
    if (ld) begin
      ser_data_d = mem_q[front_d][color_d][row_d][bit_d];
      ser_clk_d  = 1'b0;
      for (int c = 0; c < COLORS; c++) begin
        col_sel_d[c] = !((CW'(c) == color_d) && (bit_d == row_d));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      color_q    <= '0;
      bit_q      <= '0;
      phase_q    <= 1'b0;
      front_q    <= 1'b0;
      pend_q     <= 1'b0;
      ser_data_q <= 1'b0;
      col_sel_q  <= '1;
      ser_clk_q  <= 1'b0;
      latch_q    <= 1'b0;
      oe_n_q     <= 1'b1;
      ack_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      color_q    <= color_d;
      bit_q      <= bit_d;
      phase_q    <= phase_d;
      front_q    <= front_d;
      pend_q     <= pend_d;
      ser_data_q <= ser_data_d;
      col_sel_q  <= col_sel_d;
      ser_clk_q  <= ser_clk_d;
      latch_q    <= latch_d;
      oe_n_q     <= oe_n_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
    end
  end

  assign ser_data   = ser_data_q;
  assign col_sel    = col_sel_q;
  assign ser_clk    = ser_clk_q;
  assign ser_latch  = latch_q;
  assign oe_n       = oe_n_q;
  assign swap_ack   = ack_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// tb/tb_matrix_scan_driver.sv - randomized bench for matrix_scan_driver with a slot/frame reference model
module tb_matrix_scan_driver;
  localparam int N = 8, C = 2, CLK_DIV = 3;
  localparam int SLOT = (2 * N + 1) * (CLK_DIV + 1);
  localparam int FRAME = N * C * SLOT;
  localparam int SN = 4, SDIV = 1;

  logic clk = 1'b0;
  logic rst, enable, wr_en, swap_req, en_s;
  logic [0:0] wr_color;
  logic [2:0] wr_row;
  logic [N-1:0] wr_data;
  logic swap_ack, frame_done, ser_data, ser_clk, ser_latch, oe_n;
  logic [C-1:0] col_sel;
  logic s_ack, s_fd, s_data, s_clk, s_lat, s_oe;
  logic [0:0] s_cs;

  int n_chk = 0, n_pass = 0;

  // reference model state
  logic [N-1:0] shadow [2][C][N];
  bit known [2];
  int mfront = 0;
  bit mpend = 0;
  bit exp_swap = 0;
  int mslot = 0;
  bit tv_slot = 0, tv_fd = 0;

  always #5 clk = ~clk;

  matrix_scan_driver #(.N(N), .COLORS(C), .CLK_DIV(CLK_DIV)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_color(wr_color),
    .wr_row(wr_row), .wr_data(wr_data), .swap_req(swap_req), .swap_ack(swap_ack),
    .frame_done(frame_done), .ser_data(ser_data), .col_sel(col_sel),
    .ser_clk(ser_clk), .ser_latch(ser_latch), .oe_n(oe_n)
  );

  matrix_scan_driver #(.N(SN), .COLORS(1), .CLK_DIV(SDIV)) u_small (
    .clk(clk), .rst(rst), .enable(en_s), .wr_en(1'b0), .wr_color(1'b0),
    .wr_row(2'b00), .wr_data(4'b0000), .swap_req(1'b0), .swap_ack(s_ack),
    .frame_done(s_fd), .ser_data(s_data), .col_sel(s_cs),
    .ser_clk(s_clk), .ser_latch(s_lat), .oe_n(s_oe)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // slot/frame monitor for the main instance
  int cyc = 0, nb = 0, t_slot = 0, t_lat = 0, t_fd = 0;
  logic [N-1:0] cap;
  logic [N*C-1:0] cs_cap, exp_cs;
  logic p_clk = 0, p_lat = 0, p_fd = 0;
  always @(negedge clk) begin
    int k, r, c;
    logic [C-1:0] v;
    if (rst) begin
      nb = 0; tv_slot = 0; tv_fd = 0; p_clk = 0; p_lat = 0; p_fd = 0;
    end else begin
      if (ser_clk && !p_clk) begin
        cap = {cap[N-2:0], ser_data};
        cs_cap = {cs_cap[N*C-C-1:0], col_sel};
        nb++;
      end
      if (ser_latch && !p_lat) begin
        k = mslot % (N * C); r = k / C; c = k % C;
        exp_cs = '0;
        for (int b = N - 1; b >= 0; b--) begin
          v = '1;
          if (b == r) v[c] = 1'b0;
          exp_cs = {exp_cs[N*C-C-1:0], v};
        end
        check("bits_per_slot", nb, N);
        check("col_sel_walk", cs_cap, exp_cs);
        if (known[mfront]) check("row_data", cap, shadow[mfront][c][r]);
        check("oe_n_on_latch", oe_n, 0);
        if (tv_slot) check("slot_len", cyc - t_slot, SLOT);
        t_slot = cyc; tv_slot = 1; t_lat = cyc;
        nb = 0;
        mslot++;
        if (mslot % (N * C) == 0) begin
          exp_swap = mpend;
          if (mpend) mfront ^= 1;
          mpend = 0;
        end
      end
      if (!ser_latch && p_lat) check("latch_width", cyc - t_lat, CLK_DIV + 1);
      if (frame_done && !p_fd) begin
        check("frame_at_boundary", mslot % (N * C), 0);
        check("swap_ack", swap_ack, exp_swap);
        if (tv_fd) check("frame_len", cyc - t_fd, FRAME);
        t_fd = cyc; tv_fd = 1;
      end
      if (swap_ack) check("ack_with_done", frame_done, 1);
      p_clk = ser_clk; p_lat = ser_latch; p_fd = frame_done;
    end
    cyc++;
  end

  // monitor for the single-colour 4x4 instance
  int scyc = 0, snb = 0, sslot = 0, st = 0, slow = 0, slows = 0;
  bit stv = 0;
  logic sp_clk = 0, sp_lat = 0, sp_fd = 0;
  always @(negedge clk) begin
    if (rst) begin
      snb = 0; sslot = 0; stv = 0; slows = 0; sp_clk = 0; sp_lat = 0; sp_fd = 0;
    end else begin
      if (s_clk && !sp_clk) begin
        if (s_cs == 1'b0) begin slow = snb; slows++; end
        snb++;
      end
      if (s_lat && !sp_lat) begin
        check("s_bits", snb, SN);
        check("s_low_count", slows, 1);
        check("s_low_pos", slow, SN - 1 - (sslot % SN));
        if (stv) check("s_slot_len", scyc - st, (2 * SN + 1) * (SDIV + 1));
        st = scyc; stv = 1; snb = 0; slows = 0; sslot++;
      end
      if (s_fd && !sp_fd) check("s_frame_boundary", sslot % SN, 0);
      sp_clk = s_clk; sp_lat = s_lat; sp_fd = s_fd;
    end
    scyc++;
  end

  task automatic do_write(input int c, input int r, input logic [N-1:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_color = 1'(c); wr_row = 3'(r); wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    shadow[mfront ^ 1][c][r] = d;
  endtask

  task automatic fill_back();
    logic [N-1:0] d;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < C; c++) begin
        d = N'($urandom);
        if (c == 0 && r == 2 && mfront == 0) d = 8'hA5;
        do_write(c, r, d);
      end
    known[mfront ^ 1] = 1;
  endtask

  task automatic wait_fd();
    int n = 0;
    do begin @(negedge clk); n++; end while (!frame_done && n < 3 * FRAME);
    if (n >= 3 * FRAME) check("frame_done_timeout", n, 0);
  endtask

  task automatic pulse_swap();
    @(posedge clk); #1; swap_req = 1'b1; mpend = 1;
    @(posedge clk); #1; swap_req = 1'b0;
  endtask

  initial begin
    int cnt;
    rst = 1; enable = 0; en_s = 0; wr_en = 0; swap_req = 0;
    wr_color = '0; wr_row = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    fill_back();
    @(negedge clk);
    check("rst_ser_data", ser_data, 0);
    check("rst_col_sel", col_sel, 2'b11);
    check("rst_ser_clk", ser_clk, 0);
    check("rst_latch", ser_latch, 0);
    check("rst_oe_n", oe_n, 1);
    check("rst_swap_ack", swap_ack, 0);
    check("rst_frame_done", frame_done, 0);

    @(posedge clk); #1;
    rst = 0; enable = 1; en_s = 1;
    cnt = 0;
    while (cnt < 100) begin
      @(posedge clk); cnt++;
      @(negedge clk);
      if (ser_clk) break;
    end
    check("first_ser_clk", cnt, 2 * (CLK_DIV + 1));
    pulse_swap();

    wait_fd();
    fill_back();
    wait_fd();
    // request in the frame_done clk itself must wait for the following frame end
    swap_req = 1'b1; mpend = 1;
    @(posedge clk); #1; swap_req = 1'b0;
    wait_fd();

    repeat (3 * SLOT + 20) @(posedge clk);
    #1; enable = 0;
    cnt = 0;
    while (!ser_latch && cnt < 2 * SLOT) begin @(negedge clk); cnt++; end
    while (ser_latch && cnt < 2 * SLOT) begin @(negedge clk); cnt++; end
    check("drop_latch_seen", cnt < 2 * SLOT, 1);
    check("idle_oe_n", oe_n, 1);
    cnt = 0;
    repeat (60) begin @(negedge clk); if (ser_clk) cnt++; end
    check("idle_ser_clk", cnt, 0);
    mslot = 0; tv_slot = 0; tv_fd = 0;
    @(posedge clk); #1; enable = 1;

    repeat (200) @(posedge clk);
    pulse_swap();
    repeat (100) @(posedge clk);
    pulse_swap();
    wait_fd();
    wait_fd();

    repeat (30) @(posedge clk);
    #2; rst = 1;
    #1;
    check("async_oe_n", oe_n, 1);
    check("async_col_sel", col_sel, 2'b11);
    check("async_ser_clk", ser_clk, 0);
    mfront = 0; mpend = 0; mslot = 0;
    repeat (3) @(posedge clk);
    #1; rst = 0;
    wait_fd();
    repeat (20) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
